// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
//   Shares one video-memory write port (x, y, colour, plot) between NUM_REQ
//   drawing requesters and owns a full-screen clear sequencer that sweeps
//   every dot with a fill colour.
//   Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (lowest
//   asserted index always wins, no round-robin pointer). Default build is
//   round-robin. The clear sequencer and clipping are the same in both builds.
//
// Handshake (req/grant): a requester raises req[i] with its x/y/colour and
//   holds all of them until it sees grant[i]=1 in some cycle M; grant is a
//   combinational one-hot accept pulse. The dot appears on out_* with
//   out_plot=1 in cycle M+1, and in M+1 the requester may drop or replace its
//   request. A dot outside 0..X_MAX-1 / 0..Y_MAX-1 is still granted but
//   dropped (no plot). While a clear runs, grant stays 0 and requests wait.

module pixel_write_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int X_BITS      = 9,
   parameter int Y_BITS      = 8,
   parameter int COLOUR_BITS = 6,
   parameter int X_MAX       = 320,
   parameter int Y_MAX       = 240
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*X_BITS-1:0]       req_x,
   input  logic [NUM_REQ*Y_BITS-1:0]       req_y,
   input  logic [NUM_REQ*COLOUR_BITS-1:0]  req_colour,
   output logic [NUM_REQ-1:0]              grant,
   input  logic                            clear_start,
   input  logic [COLOUR_BITS-1:0]          clear_colour,
   output logic                            clear_busy,
   output logic [X_BITS-1:0]               out_x,
   output logic [Y_BITS-1:0]               out_y,
   output logic [COLOUR_BITS-1:0]          out_colour,
   output logic                            out_plot,
   output logic                            fsm_state      // debug: 0=IDLE, 1=CLEAR
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [X_BITS-1:0] CX_LAST = X_BITS'(X_MAX - 1);
   localparam logic [Y_BITS-1:0] CY_LAST = Y_BITS'(Y_MAX - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [X_BITS-1:0]       cx;
   logic [Y_BITS-1:0]       cy;
   logic [COLOUR_BITS-1:0]  fill;

   logic                    arb_valid;
   logic [PTR_W-1:0]        arb_idx;
   logic                    take;
   logic [X_BITS-1:0]       sel_x;
   logic [Y_BITS-1:0]       sel_y;
   logic [COLOUR_BITS-1:0]  sel_colour;
   logic                    in_range;
   logic                    clear_last;

`ifdef ARB_FIXED_PRIORITY_EN
   // Fixed priority: the lowest asserted index wins (scan high to low, last hit sticks).
   always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[PTR_W'(i)]) begin
            arb_valid = 1'b1;
            arb_idx   = PTR_W'(i);
         end
      end
   end
`else
   logic [PTR_W-1:0] last;
   int               rr_idx;

   // Round-robin: first asserted index searching last+1, last+2, ... modulo NUM_REQ.
   always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      rr_idx    = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         rr_idx = int'(last) + k;
         if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
         if (req[PTR_W'(rr_idx)]) begin
            arb_valid = 1'b1;
            arb_idx   = PTR_W'(rr_idx);
         end
      end
   end

   // Pointer moves to the requester that was just granted.
   always_ff @(posedge clock) begin
      if (reset) begin
         last <= PTR_W'(NUM_REQ - 1);
      end else if (take) begin
         last <= arb_idx;
      end
   end
`endif

   // Winner's data and its on-screen check.
   always_comb begin
      sel_x      = req_x[int'(arb_idx) * X_BITS +: X_BITS];
      sel_y      = req_y[int'(arb_idx) * Y_BITS +: Y_BITS];
      sel_colour = req_colour[int'(arb_idx) * COLOUR_BITS +: COLOUR_BITS];
      in_range   = ({1'b0, sel_x} < (X_BITS + 1)'(X_MAX)) &&
                   ({1'b0, sel_y} < (Y_BITS + 1)'(Y_MAX));
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a clear start always wins over requests; the clear ends on its last dot.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (clear_start) state_nxt = S_CLEAR;
         S_CLEAR: if (clear_last)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: grant only in IDLE when no clear is starting; busy mirrors the state flop.
   always_comb begin
      clear_last = (cx == CX_LAST) && (cy == CY_LAST);
      take       = (state == S_IDLE) && !clear_start && arb_valid;
      grant      = '0;
      if (take) grant = NUM_REQ'(1) << arb_idx;
      clear_busy = (state == S_CLEAR);
      fsm_state  = state;
   end

   // Write-port register and clear counters; out_* hold their value when nothing plots.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_x      <= '0;
         out_y      <= '0;
         out_colour <= '0;
         out_plot   <= 1'b0;
         cx         <= '0;
         cy         <= '0;
         fill       <= '0;
      end else begin
         out_plot <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clear_start) begin
                  fill <= clear_colour;
                  cx   <= '0;
                  cy   <= '0;
               end else if (take && in_range) begin
                  out_x      <= sel_x;
                  out_y      <= sel_y;
                  out_colour <= sel_colour;
                  out_plot   <= 1'b1;
               end
            end
            S_CLEAR: begin
               out_x      <= cx;
               out_y      <= cy;
               out_colour <= fill;
               out_plot   <= 1'b1;
               if (cx == CX_LAST) begin
                  cx <= '0;
                  if (cy != CY_LAST) cy <= cy + 1'b1;
               end else begin
                  cx <= cx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter on a small 4x2 screen so full clears are short.
// A reference model runs on every falling edge: it predicts grant, clear_busy
// and out_plot, and queues each expected dot, which is popped when the DUT
// should be plotting it. Directed sequences follow, then random traffic.

module tb_pixel_write_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int X_BITS      = 9;
   localparam int Y_BITS      = 8;
   localparam int COLOUR_BITS = 6;
   localparam int X_MAX       = 4;
   localparam int Y_MAX       = 2;
   localparam int DW          = X_BITS + Y_BITS + COLOUR_BITS;

   logic                           clock = 1'b0;
   logic                           reset = 1'b1;
   logic [NUM_REQ-1:0]             req = '0;
   logic [NUM_REQ*X_BITS-1:0]      req_x = '0;
   logic [NUM_REQ*Y_BITS-1:0]      req_y = '0;
   logic [NUM_REQ*COLOUR_BITS-1:0] req_colour = '0;
   logic [NUM_REQ-1:0]             grant;
   logic                           clear_start = 1'b0;
   logic [COLOUR_BITS-1:0]         clear_colour = '0;
   logic                           clear_busy;
   logic [X_BITS-1:0]              out_x;
   logic [Y_BITS-1:0]              out_y;
   logic [COLOUR_BITS-1:0]         out_colour;
   logic                           out_plot;
   logic                           fsm_state;

   pixel_write_arbiter #(
      .NUM_REQ(NUM_REQ), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
      .COLOUR_BITS(COLOUR_BITS), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
   ) dut (
      .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
      .req_colour(req_colour), .grant(grant), .clear_start(clear_start),
      .clear_colour(clear_colour), .clear_busy(clear_busy), .out_x(out_x),
      .out_y(out_y), .out_colour(out_colour), .out_plot(out_plot),
      .fsm_state(fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- scoreboard state ----------------
   int vectors = 0;
   int miscompares = 0;
   logic [DW-1:0] exp_q[$];

   logic                   mon_en = 1'b0;
   logic [NUM_REQ-1:0]     g_last = '0;
   logic                   m_busy = 1'b0;
   int                     m_last = NUM_REQ - 1;
   logic                   m_plot = 1'b0;
   int                     m_cx = 0;
   int                     m_cy = 0;
   logic [COLOUR_BITS-1:0] m_fill = '0;
   logic [NUM_REQ-1:0]     mon_eg;
   int                     mon_gi;
   logic [X_BITS-1:0]      gx;
   logic [Y_BITS-1:0]      gy;
   logic [COLOUR_BITS-1:0] gc;
   logic [DW-1:0]          want;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   always @(negedge clock) begin
      if (mon_en) begin
         mon_eg = '0;
         mon_gi = -1;
         if (!m_busy && !clear_start) begin
`ifdef ARB_FIXED_PRIORITY_EN
            for (int k = 0; k < NUM_REQ; k++)
               if (req[k] && mon_gi < 0) mon_gi = k;
`else
            for (int k = 1; k <= NUM_REQ; k++)
               if (req[(m_last + k) % NUM_REQ] && mon_gi < 0) mon_gi = (m_last + k) % NUM_REQ;
`endif
            if (mon_gi >= 0) mon_eg[mon_gi] = 1'b1;
         end
         check("grant", 32'(grant), 32'(mon_eg));
         check("busy", 32'(clear_busy), 32'(m_busy));
         check("plot", 32'(out_plot), 32'(m_plot));
         if (m_plot) begin
            if (exp_q.size() == 0) begin
               check("dot_q", 32'(0), 32'(1));
            end else begin
               want = exp_q.pop_front();
               if (out_plot) check("dot", 32'({out_x, out_y, out_colour}), 32'(want));
            end
         end
         g_last = grant;

         if (reset) begin
            m_busy = 1'b0; m_last = NUM_REQ - 1; m_plot = 1'b0;
            m_cx = 0; m_cy = 0; m_fill = '0;
            exp_q.delete();
         end else if (!m_busy) begin
            m_plot = 1'b0;
            if (clear_start) begin
               m_busy = 1'b1; m_fill = clear_colour; m_cx = 0; m_cy = 0;
            end else if (mon_gi >= 0) begin
               m_last = mon_gi;
               gx = req_x[mon_gi*X_BITS +: X_BITS];
               gy = req_y[mon_gi*Y_BITS +: Y_BITS];
               gc = req_colour[mon_gi*COLOUR_BITS +: COLOUR_BITS];
               if (gx < X_MAX && gy < Y_MAX) begin
                  m_plot = 1'b1;
                  exp_q.push_back({gx, gy, gc});
               end
            end
         end else begin
            exp_q.push_back({X_BITS'(m_cx), Y_BITS'(m_cy), m_fill});
            m_plot = 1'b1;
            if (m_cx == X_MAX - 1) begin
               m_cx = 0;
               if (m_cy == Y_MAX - 1) m_busy = 1'b0;
               else m_cy++;
            end else begin
               m_cx++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; clear_start = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic set_req(input int i, input int x, input int y, input int c);
      req[i] = 1'b1;
      req_x[i*X_BITS +: X_BITS] = X_BITS'(x);
      req_y[i*Y_BITS +: Y_BITS] = Y_BITS'(y);
      req_colour[i*COLOUR_BITS +: COLOUR_BITS] = COLOUR_BITS'(c);
   endtask

   task automatic drop_granted();
      for (int i = 0; i < NUM_REQ; i++)
         if (g_last[i]) req[i] = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic             busy_a[13];
   logic             plot_a[13];
   int               first_g;
   logic [NUM_REQ-1:0] served;
   logic [NUM_REQ-1:0] exp_g;

   initial begin
      tick();
      mon_en = 1'b1;
      tick(); tick();
      reset = 1'b0;

      // reset state
      @(negedge clock);
      check("rst_x", 32'(out_x), 32'(0));
      check("rst_y", 32'(out_y), 32'(0));
      check("rst_col", 32'(out_colour), 32'(0));
      check("rst_plot", 32'(out_plot), 32'(0));
      check("rst_busy", 32'(clear_busy), 32'(0));
      check("rst_state", 32'(fsm_state), 32'(0));
      tick();

      // single request on requester 2
      set_req(2, 3, 1, 'h2A);
      @(negedge clock);
      check("t1_grant", 32'(grant), 32'(4'b0100));
      tick();
      req[2] = 1'b0;
      @(negedge clock);
      check("t1_plot", 32'(out_plot), 32'(1));
      check("t1_x", 32'(out_x), 32'(3));
      check("t1_y", 32'(out_y), 32'(1));
      check("t1_col", 32'(out_colour), 32'(6'h2A));
      tick();

      // all four held: rotation (or fixed winner)
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, i, i % 2, 8 + i);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
`ifdef ARB_FIXED_PRIORITY_EN
         exp_g = 4'b0001;
`else
         exp_g = 4'b0001 << (k % 4);
`endif
         check("t2_grant", 32'(grant), 32'(exp_g));
         check("t2_plot", 32'(out_plot), 32'(k > 0));
         tick();
      end
      req = '0;
      tick();

      // clear with a request in the start cycle and another arriving next cycle
      clear_start = 1'b1; clear_colour = 6'h3F;
      set_req(0, 1, 0, 'h11);
      first_g = -1; served = '0;
      for (int j = 0; j < 13; j++) begin
         @(negedge clock);
         busy_a[j] = clear_busy;
         plot_a[j] = out_plot;
         if (grant != '0 && first_g < 0) first_g = j;
         served = served | grant;
         if (j == 0) check("t4_grant0", 32'(grant), 32'(0));
         tick();
         if (j == 0) begin
            clear_start = 1'b0;
            set_req(1, 2, 1, 'h05);
         end
         drop_granted();
      end
      for (int j = 0; j < 13; j++) begin
         check("t3_busy", 32'(busy_a[j]), 32'(j >= 1 && j <= 8));
         if (j <= 9) check("t3_plot", 32'(plot_a[j]), 32'(j >= 2));
      end
      check("t3_first_grant", 32'(first_g), 32'(9));
      check("t4_served", 32'(served), 32'(4'b0011));
      req = '0;
      tick();

      // clipping: x = X_MAX, then a normal replacement, then y = Y_MAX and x = 320
      set_req(3, X_MAX, 1, 'h07);
      @(negedge clock);
      check("t5_grant", 32'(grant), 32'(4'b1000));
      tick();
      set_req(3, 3, 1, 'h15);
      @(negedge clock);
      check("t5_clip_plot", 32'(out_plot), 32'(0));
      check("t5_grant2", 32'(grant), 32'(4'b1000));
      tick();
      req = '0;
      set_req(0, 0, Y_MAX, 'h01);
      @(negedge clock);
      check("t5_plot2", 32'(out_plot), 32'(1));
      check("t5_x2", 32'(out_x), 32'(3));
      check("t5_col2", 32'(out_colour), 32'(6'h15));
      tick();
      set_req(0, 320, 5, 'h02);
      @(negedge clock);
      check("t5_yclip_plot", 32'(out_plot), 32'(0));
      tick();
      req = '0;
      @(negedge clock);
      check("t5_xclip_plot", 32'(out_plot), 32'(0));
      tick();

      // reset in the third clear cycle
      clear_start = 1'b1; clear_colour = 6'h0C;
      tick();
      clear_start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("t6_busy", 32'(clear_busy), 32'(0));
      check("t6_plot", 32'(out_plot), 32'(0));
      check("t6_x", 32'(out_x), 32'(0));
      check("t6_y", 32'(out_y), 32'(0));
      check("t6_col", 32'(out_colour), 32'(0));
      check("t6_state", 32'(fsm_state), 32'(0));
      for (int j = 0; j < 4; j++) begin
         tick();
         @(negedge clock);
         check("t6_quiet", 32'(out_plot), 32'(0));
      end
      tick();

      // random traffic with occasional clears
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] || g_last[i]) begin
               if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
               else set_req(i, $urandom_range(0, X_MAX), $urandom_range(0, Y_MAX),
                            $urandom_range(0, 63));
            end
         end
         clear_start  = ($urandom_range(0, 39) == 0);
         clear_colour = COLOUR_BITS'($urandom_range(0, 63));
         tick();
      end
      req = '0; clear_start = 1'b0;
      repeat (12) tick();
      @(negedge clock);
      check("q_drain", 32'(exp_q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
